fifo_rd_checker: RTL
====================

Name: fifo_rd_checker

Overview:
- Read-side consumer for the team's FIFOs; sits on the FIFO read port in the read clock domain.
- Drains a programmed number of words, optionally with pseudo-random gaps between reads.
- Checks each word against an expected incrementing sequence and reports counts and pass/fail.
- Synthesizable counterpart to the bench write stimulus, for on-chip FIFO self-test.

Parameters:
- WIDTH, 8, data width; equals the FIFO WIDTH.
- CNT_WIDTH, 16, width of read/error counters and num_rd_i.
- DATA_START, 0, expected value of the first word; WIDTH bits.
- MAX_RD_DELAY, 10, random gaps fall in 0..MAX_RD_DELAY-1 idle cycles; range 1..255.
- GAP_SEED, 16'hACE1, reset/start value of the gap LFSR; must be nonzero.

Ports:
- clk_i  input  1  read-domain clock; all logic on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  one-cycle start pulse; honoured only in IDLE or DONE.
- num_rd_i  input  CNT_WIDTH  number of words to read; latched on start.
- gap_en_i  input  1  1 = random gaps, 0 = back-to-back; latched on start.
- empty_i  input  1  FIFO empty flag.
- rdata_i  input  WIDTH  FIFO read data; valid the cycle after an accepted read.
- rd_error_i  input  1  FIFO read-underflow error.
- rd_en_o  output  1  FIFO read enable.
- busy_o  output  1  high in READ, GAP and DRAIN.
- done_o  output  1  high in DONE.
- pass_o  output  1  done_o & (err_cnt_o==0) & ~proto_err_o.
- rd_cnt_o  output  CNT_WIDTH  words compared so far.
- err_cnt_o  output  CNT_WIDTH  mismatches; saturates at all-ones.
- first_err_o  output  WIDTH  rdata_i of the first mismatch; 0 if none.
- proto_err_o  output  1  sticky; rd_error_i seen while busy.

Behaviour:
Reset:
- State goes to IDLE. All outputs and counters go to 0.
- Gap LFSR loads GAP_SEED. Expected register loads DATA_START.
- rd_en_o is gated by ~rst_i, so it is 0 in any cycle where rst_i=1.
- Reset mid-operation abandons the run; no done_o is produced.

rd_en_o:
- rd_en_o = (state==READ) & ~empty_i & ~rst_i (combinational).
- "Accept" = rd_en_o high at a clock edge.
- Never asserted while empty_i=1; the checker itself can never cause an underflow.

Read latency and compare:
- A registered valid flag vld_q is set on each accept.
- In the cycle vld_q=1:
  - Compare rdata_i against exp.
  - rd_cnt_o increments; exp increments mod 2^WIDTH.
  - On mismatch, err_cnt_o increments (saturating). The first mismatch also captures first_err_o.

State machine: IDLE, READ, GAP, DRAIN, DONE.
- IDLE/DONE with start_i:
  - Latch num_rd_i and gap_en_i; issued <= 0.
  - Clear rd_cnt_o, err_cnt_o, first_err_o and proto_err_o.
  - exp <= DATA_START; LFSR <= GAP_SEED.
  - If num_rd_i==0, go to DONE; else go to READ.
- READ:
  - Stays while empty_i=1.
  - On accept: issued++.
  - If issued+1==num, go to DRAIN.
  - Else if gap_en=1 and gap g!=0, load gap counter with g and go to GAP.
  - Otherwise remain in READ (reads back-to-back).
- Gap value: g = lfsr[15:0] % MAX_RD_DELAY.
  - LFSR is Fibonacci x^16+x^14+x^13+x^11+1.
  - LFSR steps once per accept, only when gap_en=1.
- GAP: decrement the counter each cycle; return to READ after it reaches 1. The gap lasts exactly g idle cycles.
- DRAIN: one cycle; the final compare happens here. Then go to DONE.
- DONE:
  - done_o=1; all results are held until the next start_i or reset.
  - start_i in DONE is handled exactly as in IDLE.

Other rules:
- start_i is ignored in READ, GAP and DRAIN.
- rd_error_i=1 while busy sets proto_err_o; it does not change the state.
- Counters wrap mod 2^CNT_WIDTH, except err_cnt_o, which saturates.

Test Plan:
1. FIFO preloaded with 0..15, start with num=16 and gap_en=0 -> rd_en_o high for 16 consecutive cycles; done_o 2 cycles after the last accept; rd_cnt_o=16, err_cnt_o=0, pass_o=1.
2. FIFO preloaded 0..15 with word 5 replaced by 8'hFF, num=16 -> err_cnt_o=1, first_err_o=8'hFF, pass_o=0. Word 6 still compares OK (exp keeps counting).
3. FIFO empty, start with num=4, then write 0..3 one per 20 cycles -> no rd_en_o while empty_i=1; four accepts; pass_o=1; proto_err_o=0.
4. num=200 with gap_en=1 against a concurrently written FIFO -> idle cycles between accepts match the LFSR sequence from 16'hACE1, each 0..9; rd_cnt_o=200; pass_o=1.
5. rst_i pulsed in READ after 3 of 16 reads -> next cycle rd_en_o=0, state IDLE, all counters 0. A new start with num=13 on the remaining data 3..15 needs DATA_START=3 for pass_o=1; with DATA_START=0 it gives err_cnt_o=13.
6. num=0 start -> done_o the next cycle, rd_en_o never asserted, pass_o=1. Forced rd_error_i pulse while busy in another run -> proto_err_o=1, pass_o=0.

Source files
------------

// File: rtl/fifo_rd_checker.sv
// rtl/fifo_rd_checker.sv - FIFO read-side self-test checker
//
// Drains num_rd_i words from a FIFO read port, optionally with LFSR-driven
// idle gaps, and checks them against an incrementing sequence.
//
// Ports:
//   clk_i        read-domain clock
//   rst_i        synchronous active-high reset
//   start_i      start pulse, honoured in IDLE or DONE
//   num_rd_i     number of words to read (latched on start)
//   gap_en_i     enable random gaps between reads (latched on start)
//   empty_i      FIFO empty flag
//   rdata_i      FIFO read data, valid the cycle after an accepted read
//   rd_error_i   FIFO read-underflow error
//   rd_en_o      FIFO read enable
//   busy_o       run in progress (READ, GAP, DRAIN)
//   done_o       run finished, results held
//   pass_o       done with no mismatches and no protocol error
//   rd_cnt_o     words compared
//   err_cnt_o    mismatches, saturating
//   first_err_o  data of the first mismatching word
//   proto_err_o  sticky: rd_error_i seen while busy
module fifo_rd_checker #(
  parameter int               WIDTH        = 8,
  parameter int               CNT_WIDTH    = 16,
  parameter logic [WIDTH-1:0] DATA_START   = '0,
  parameter int               MAX_RD_DELAY = 10,
  parameter logic [15:0]      GAP_SEED     = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] num_rd_i,
  input  logic                 gap_en_i,
  input  logic                 empty_i,
  input  logic [WIDTH-1:0]     rdata_i,
  input  logic                 rd_error_i,
  output logic                 rd_en_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [CNT_WIDTH-1:0] rd_cnt_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic [WIDTH-1:0]     first_err_o,
  output logic                 proto_err_o
);

  localparam logic [15:0] GAP_DIV = 16'(MAX_RD_DELAY);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_GAP   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [CNT_WIDTH-1:0] num_q;
  logic [CNT_WIDTH-1:0] issued_q;
  logic                 gap_en_q;
  logic [15:0]          lfsr_q;
  logic [15:0]          lfsr_nxt;
  logic [7:0]           gap_cnt_q;
  logic [7:0]           gap_val;
  logic                 vld_q;
  logic [WIDTH-1:0]     exp_q;
  logic                 accept;
  logic                 start_ok;
  logic                 last_rd;

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0
  assign lfsr_nxt = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign gap_val  = 8'(lfsr_q % GAP_DIV);

  assign accept   = rd_en_o;
  assign start_ok = start_i & ((state_q == S_IDLE) | (state_q == S_DONE));
  // This accept is the final one of the run
  assign last_rd  = (issued_q + CNT_WIDTH'(1)) == num_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = (num_rd_i == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (accept) begin
          if (last_rd) begin
            state_d = S_DRAIN;
          end else if (gap_en_q && (gap_val != 8'd0)) begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 8'd1) begin
          state_d = S_READ;
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    rd_en_o = (state_q == S_READ) & ~empty_i & ~rst_i;
    busy_o  = (state_q == S_READ) | (state_q == S_GAP) | (state_q == S_DRAIN);
    done_o  = (state_q == S_DONE);
    pass_o  = done_o & (err_cnt_o == '0) & ~proto_err_o;
  end

  // Run parameters, gap generator and result counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      num_q       <= '0;
      issued_q    <= '0;
      gap_en_q    <= 1'b0;
      lfsr_q      <= GAP_SEED;
      gap_cnt_q   <= '0;
      vld_q       <= 1'b0;
      exp_q       <= DATA_START;
      rd_cnt_o    <= '0;
      err_cnt_o   <= '0;
      first_err_o <= '0;
      proto_err_o <= 1'b0;
    end else begin
      vld_q <= accept;
      if (start_ok) begin
        num_q       <= num_rd_i;
        gap_en_q    <= gap_en_i;
        issued_q    <= '0;
        lfsr_q      <= GAP_SEED;
        exp_q       <= DATA_START;
        rd_cnt_o    <= '0;
        err_cnt_o   <= '0;
        first_err_o <= '0;
        proto_err_o <= 1'b0;
      end else begin
        if (accept) begin
          issued_q  <= issued_q + CNT_WIDTH'(1);
          gap_cnt_q <= gap_val;
          if (gap_en_q) begin
            lfsr_q <= lfsr_nxt;
          end
        end
        if (state_q == S_GAP) begin
          gap_cnt_q <= gap_cnt_q - 8'd1;
        end
        // Data from the previous cycle's accept is on rdata_i now
        if (vld_q) begin
          rd_cnt_o <= rd_cnt_o + CNT_WIDTH'(1);
          exp_q    <= exp_q + WIDTH'(1);
          if (rdata_i != exp_q) begin
            if (err_cnt_o == '0) begin
              first_err_o <= rdata_i;
            end
            if (err_cnt_o != '1) begin
              err_cnt_o <= err_cnt_o + CNT_WIDTH'(1);
            end
          end
        end
        if (rd_error_i && busy_o) begin
          proto_err_o <= 1'b1;
        end
      end
    end
  end

endmodule
